sig_mix_gen: RTL and testbench
==============================

SIG_MIX_GEN -- requirements
Module: sig_mix_gen

Interface
REQ-001 SHALL expose parameter PHASE_W, default 32, phase accumulator and frequency-word width.
REQ-002 SHALL expose parameter LUT_AW, default 10, sine LUT address width (LUT has 2^LUT_AW entries).
REQ-003 SHALL expose parameter DATA_W, default 10, signed per-tone sample width; the mix output is DATA_W+1 bits.
REQ-004 SHALL expose parameter SMP_DIV, default 1, clocks per output sample (>=1).
REQ-005 sys_clk  input  1  sole clock; all logic on the rising edge.
REQ-006 sys_rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  run enable; low freezes the sample counter and accumulators.
REQ-008 cfg_wr  input  1  one-cycle strobe; latches fcw_a/fcw_b.
REQ-009 cfg_clr  input  1  one-cycle strobe; zeroes both phase accumulators and ovf.
REQ-010 fcw_a, fcw_b  input  PHASE_W  frequency control words for tone A and tone B.
REQ-011 tone_a, tone_b  output  DATA_W signed  per-tone samples, aligned with mix_out.
REQ-012 mix_out  output  DATA_W+1 signed  tone_a + tone_b (stimulus for the separator).
REQ-013 out_valid / out_ready  output / input  1  stream handshake; transfer when both are high.
REQ-014 ovf  output  1  sticky: a sample was overwritten before it was accepted.

Function
REQ-015 Tick counter SHALL count 0..SMP_DIV-1 while en=1 and assert tick when it equals SMP_DIV-1, then wrap to 0; SMP_DIV=1 SHALL tick every enabled cycle.
REQ-016 On tick, each accumulator SHALL add its active fcw modulo 2^PHASE_W, with natural wrap-around.
REQ-017 cfg_wr SHALL load the shadow fcw registers; the active fcw SHALL update at the next tick, without resetting phase (phase-continuous retune).
REQ-018 cfg_clr SHALL zero both accumulators on the next edge; if cfg_clr and tick coincide, clear SHALL win; if cfg_clr and cfg_wr coincide, both SHALL take effect.
REQ-019 LUT address SHALL be accumulator[PHASE_W-1 -: LUT_AW]; entry k = round((2^(DATA_W-1)-1)*sin(2*pi*k/2^LUT_AW)), i.e. ±511 peak for DATA_W=10.
REQ-020 Pipeline: accumulator update (S0), registered LUT read (S1), sum plus output register (S2); out_valid SHALL rise exactly 3 cycles after the tick edge.
REQ-021 mix_out SHALL be the sign-extended full-precision sum; no saturation is needed or permitted.
REQ-022 out_valid SHALL stay high with data held stable until accepted, and SHALL drop the cycle after acceptance unless a new sample lands in the same cycle.
REQ-023 If a new sample reaches S2 while out_valid=1 and out_ready=0, it SHALL overwrite the data and set ovf; ovf SHALL clear only on cfg_clr or reset.
REQ-024 en deassert SHALL stop new ticks; samples already in the pipeline SHALL drain normally.

Reset
REQ-025 On sys_rst=1: accumulators, active/shadow fcw, tick counter and pipeline valids SHALL be 0; tone_a, tone_b, mix_out, out_valid and ovf SHALL be 0.
REQ-026 Reset mid-stream SHALL discard in-flight samples; the first post-reset out_valid SHALL come no earlier than 3 cycles after the first tick.

Configuration
REQ-027 Macro MIX_PHASE_OFS_EN defined: add input phase_ofs_b (PHASE_W bits), latched by cfg_wr and added to tone B's accumulator before LUT addressing.
REQ-028 Macro MIX_PHASE_OFS_EN undefined: port absent; tone B is addressed by its accumulator directly.

Structure
REQ-029 Shared package sig_sep_pkg SHALL hold DATA_W, PHASE_W and LUT_AW defaults, the signed sample typedef and the mix-sample typedef.
REQ-030 Sine ROM SHALL be sub-module sine_lut (registered read, one instance per tone, or one dual-port instance).

Verification
REQ-031 Reset, fcw_a=fcw_b=2^30, cfg_wr, en=1, out_ready=1 -> mix_out sequence 1022, 0, -1022, 0 repeating; tone_a = tone_b.
REQ-032 fcw_a=2^22, fcw_b=0 -> tone_a steps through LUT entries 1,2,3,...; tone_b=0; mix_out=tone_a.
REQ-033 out_ready=0 for 5 ticks -> out_valid held, data frozen, ovf=1; cfg_clr -> ovf=0, accumulators 0.
REQ-034 SMP_DIV=4 -> one out_valid pulse every 4 cycles, each 3 cycles after its tick.
REQ-035 Retune by cfg_wr mid-stream -> no phase jump at the first tick using the new fcw; reset asserted mid-stream -> all outputs 0 on the next edge.
REQ-036 With MIX_PHASE_OFS_EN, fcw_a=fcw_b=2^30 and phase_ofs_b=2^31 -> mix_out constant 0.

Source files
------------

// File: rtl/sig_sep_pkg.sv
// Shared definitions for the tone generator / separator slice.
//   SIG_PHASE_W, SIG_LUT_AW, SIG_DATA_W : default widths
//   sample_t  : signed per-tone sample (SIG_DATA_W bits)
//   mix_t     : signed two-tone sum (SIG_DATA_W+1 bits)
//   sine_entry: constant function giving one sine ROM entry
package sig_sep_pkg;

    localparam int SIG_PHASE_W = 32;
    localparam int SIG_LUT_AW  = 10;
    localparam int SIG_DATA_W  = 10;

    typedef logic signed [SIG_DATA_W-1:0] sample_t;
    typedef logic signed [SIG_DATA_W:0]   mix_t;

    // round((2^(data_w-1)-1) * sin(2*pi*k/2^lut_aw)), rounding half away
    // from zero. Only ever evaluated at elaboration time.
    function automatic int sine_entry(int k, int lut_aw, int data_w);
        real amp;
        real x;
        amp = real'((1 << (data_w - 1)) - 1);
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << lut_aw));
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-period sine ROM with a registered read (one clock of latency).
//   sys_clk : clock
//   addr    : LUT_AW-bit phase index
//   data    : signed DATA_W-bit sample, valid one cycle after addr
module sine_lut
    import sig_sep_pkg::*;
#(
    parameter int LUT_AW = SIG_LUT_AW,
    parameter int DATA_W = SIG_DATA_W
) (
    input  logic                     sys_clk,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    logic signed [DATA_W-1:0] rom [1 << LUT_AW];

    for (genvar k = 0; k < (1 << LUT_AW); k++) begin : g_rom
        localparam int VAL = sine_entry(k, LUT_AW, DATA_W);
        assign rom[k] = DATA_W'(VAL);
    end

    // No reset: the output is only consumed when the pipeline valid says so.
    always_ff @(posedge sys_clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/sig_mix_gen.sv
// Two-tone DDS stimulus generator: two phase accumulators address sine
// ROMs; the two tones and their full-precision sum leave on a stream port.
//
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   en                 run enable (freezes the sample counter when low)
//   cfg_wr             strobe: latch fcw_a/fcw_b (and phase_ofs_b) into shadows
//   cfg_clr            strobe: zero both phase accumulators and ovf
//   fcw_a, fcw_b       frequency control words
//   phase_ofs_b        tone B phase offset (only with MIX_PHASE_OFS_EN)
//   tone_a, tone_b     per-tone samples aligned with mix_out
//   mix_out            tone_a + tone_b, sign-extended, never saturated
//   out_valid/ready    output stream handshake
//   ovf                sticky: an unaccepted sample was overwritten
//
// Build option: define MIX_PHASE_OFS_EN to add the phase_ofs_b input.
//
// Pipeline (cycles after the edge where the sample counter wraps):
//   tick register -> +1 accumulator update (S0) -> +2 ROM read (S1)
//   -> +3 sum / output register (S2), out_valid rises.
//
// Handshake: a sample transfers on any rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready low the
// data is held, unless a new sample reaches S2, which overwrites it and
// sets ovf. out_valid drops the cycle after a transfer unless a new
// sample lands on that same edge.
module sig_mix_gen
    import sig_sep_pkg::*;
#(
    parameter int PHASE_W = SIG_PHASE_W,
    parameter int LUT_AW  = SIG_LUT_AW,
    parameter int DATA_W  = SIG_DATA_W,
    parameter int SMP_DIV = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     en,
    input  logic                     cfg_wr,
    input  logic                     cfg_clr,
    input  logic [PHASE_W-1:0]       fcw_a,
    input  logic [PHASE_W-1:0]       fcw_b,
`ifdef MIX_PHASE_OFS_EN
    input  logic [PHASE_W-1:0]       phase_ofs_b,
`endif
    output logic signed [DATA_W-1:0] tone_a,
    output logic signed [DATA_W-1:0] tone_b,
    output logic signed [DATA_W:0]   mix_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf
);

    localparam int CNT_W = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SMP_DIV - 1);

    // ---------------- sample tick ----------------
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= en && (tick_cnt == CNT_LAST);
            if (en)
                tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // ---------------- frequency words and accumulators (S0) ----------------
    logic [PHASE_W-1:0] shadow_a, shadow_b;
    logic [PHASE_W-1:0] active_a, active_b;
    logic [PHASE_W-1:0] active_next_a, active_next_b;
    logic [PHASE_W-1:0] acc_a, acc_b;
    logic               s0_valid;

    // The shadow becomes active at a tick and is used by that same tick,
    // so a retune never disturbs the phase already accumulated.
    always_comb begin
        active_next_a = active_a;
        active_next_b = active_b;
        if (tick) begin
            active_next_a = shadow_a;
            active_next_b = shadow_b;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shadow_a <= '0;
            shadow_b <= '0;
            active_a <= '0;
            active_b <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            s0_valid <= 1'b0;
        end else begin
            if (cfg_wr) begin
                shadow_a <= fcw_a;
                shadow_b <= fcw_b;
            end
            active_a <= active_next_a;
            active_b <= active_next_b;
            // Clear beats a coincident tick; the tick still emits a sample
            // (of the zeroed phase).
            if (cfg_clr) begin
                acc_a <= '0;
                acc_b <= '0;
            end else if (tick) begin
                acc_a <= acc_a + active_next_a;
                acc_b <= acc_b + active_next_b;
            end
            s0_valid <= tick;
        end
    end

    // ---------------- ROM read (S1) ----------------
    logic [PHASE_W-1:0]       phase_b;
    logic signed [DATA_W-1:0] lut_a, lut_b;
    logic                     s1_valid;

`ifdef MIX_PHASE_OFS_EN
    logic [PHASE_W-1:0] ofs_b;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            ofs_b <= '0;
        else if (cfg_wr)
            ofs_b <= phase_ofs_b;
    end

    assign phase_b = acc_b + ofs_b;
`else
    assign phase_b = acc_b;
`endif

    sine_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut_a (
        .sys_clk (sys_clk),
        .addr    (acc_a[PHASE_W-1 -: LUT_AW]),
        .data    (lut_a)
    );

    sine_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut_b (
        .sys_clk (sys_clk),
        .addr    (phase_b[PHASE_W-1 -: LUT_AW]),
        .data    (lut_b)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            s1_valid <= 1'b0;
        else
            s1_valid <= s0_valid;
    end

    // ---------------- sum and output register (S2) ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tone_a    <= '0;
            tone_b    <= '0;
            mix_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s1_valid) begin
                tone_a    <= lut_a;
                tone_b    <= lut_b;
                mix_out   <= {lut_a[DATA_W-1], lut_a} + {lut_b[DATA_W-1], lut_b};
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (cfg_clr)
                ovf <= 1'b0;
            else if (s1_valid && out_valid && !out_ready)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sig_mix_gen.sv
module tb_sig_mix_gen;
  import sig_sep_pkg::*;

  localparam int PW = 32;
  localparam int AW = 10;
  localparam int DW = 10;
  localparam int MAIN_DIV = 1;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst, en, en_d4, cfg_wr, cfg_clr, out_ready;
  logic [PW-1:0] fcw_a, fcw_b, phase_ofs_b;
  sample_t tone_a, tone_b, d4_tone_a, d4_tone_b;
  mix_t mix_out, d4_mix;
  logic out_valid, ovf, d4_valid, d4_ovf;

  always #5 sys_clk = ~sys_clk;

  sig_mix_gen #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .SMP_DIV(MAIN_DIV)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cfg_wr(cfg_wr), .cfg_clr(cfg_clr),
    .fcw_a(fcw_a), .fcw_b(fcw_b),
`ifdef MIX_PHASE_OFS_EN
    .phase_ofs_b(phase_ofs_b),
`endif
    .tone_a(tone_a), .tone_b(tone_b), .mix_out(mix_out),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  sig_mix_gen #(.PHASE_W(PW), .LUT_AW(AW), .DATA_W(DW), .SMP_DIV(4)) u_div4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en_d4), .cfg_wr(cfg_wr), .cfg_clr(cfg_clr),
    .fcw_a(fcw_a), .fcw_b(fcw_b),
`ifdef MIX_PHASE_OFS_EN
    .phase_ofs_b(phase_ofs_b),
`endif
    .tone_a(d4_tone_a), .tone_b(d4_tone_b), .mix_out(d4_mix),
    .out_valid(d4_valid), .out_ready(1'b1), .ovf(d4_ovf)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
  } smp_t;

  smp_t exp_q[$];
  int sine_tab[1 << AW];
  logic [PW-1:0] m_ph_a, m_ph_b, m_sh_a, m_sh_b, m_ofs;
  int m_cnt;
  bit m_tick;
  int cyc;
  bit m_valid, m_ovf;
  int m_a, m_b, m_mix;
  int checks, failures;

  function automatic int tone_of(logic [PW-1:0] ph);
    return sine_tab[ph[PW-1 -: AW]];
  endfunction

  function automatic int seq_exp(int i);
`ifdef MIX_PHASE_OFS_EN
    return 0;
`else
    case (i % 4)
      0: return 1022;
      2: return -1022;
      default: return 0;
    endcase
`endif
  endfunction

  task automatic model_edge();
    bit arrive;
    bit push;
    smp_t s;
    cyc++;
    if (sys_rst) begin
      exp_q.delete();
      m_ph_a = '0; m_ph_b = '0; m_sh_a = '0; m_sh_b = '0; m_ofs = '0;
      m_cnt = 0; m_tick = 0; m_valid = 0; m_ovf = 0;
      m_a = 0; m_b = 0; m_mix = 0;
      return;
    end
    // output stage
    arrive = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (cfg_clr) m_ovf = 0;
    else if (arrive && m_valid && !out_ready) m_ovf = 1;
    if (arrive) begin
      s = exp_q.pop_front();
      m_a = tone_of(s.pa);
      m_b = tone_of(s.pb);
      m_mix = m_a + m_b;
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    // phase update for a tick issued on the previous edge
    push = 0;
    if (m_tick) begin
      push = 1;
      if (cfg_clr) begin m_ph_a = '0; m_ph_b = '0; end
      else begin m_ph_a = m_ph_a + m_sh_a; m_ph_b = m_ph_b + m_sh_b; end
    end else if (cfg_clr) begin
      m_ph_a = '0; m_ph_b = '0;
    end
    m_tick = en && (m_cnt == MAIN_DIV - 1);
    if (en) m_cnt = (m_cnt + 1) % MAIN_DIV;
    if (cfg_wr) begin
      m_sh_a = fcw_a;
      m_sh_b = fcw_b;
`ifdef MIX_PHASE_OFS_EN
      m_ofs = phase_ofs_b;
`endif
    end
    if (push) exp_q.push_back('{cyc + 2, m_ph_a, m_ph_b + m_ofs});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("out_valid", int'(out_valid), int'(m_valid));
    check("ovf", int'(ovf), int'(m_ovf));
    check("tone_a", int'(tone_a), m_a);
    check("tone_b", int'(tone_b), m_b);
    check("mix_out", int'(mix_out), m_mix);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("wait_valid", int'(out_valid), 1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic cfg(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] ofs);
    fcw_a = a; fcw_b = b; phase_ofs_b = ofs;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] ofs_demo;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int k = 0; k < (1 << AW); k++) begin
      real x;
      x = 511.0 * $sin(2.0 * 3.14159265358979323846 * k / 1024.0);
      sine_tab[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    end
`ifdef MIX_PHASE_OFS_EN
    ofs_demo = 32'h8000_0000;
`else
    ofs_demo = '0;
`endif
    sys_rst = 1'b1; en = 0; en_d4 = 0; cfg_wr = 0; cfg_clr = 0; out_ready = 0;
    fcw_a = '0; fcw_b = '0; phase_ofs_b = '0;
    step();
    step();
    check("rst_mix", int'(mix_out), 0);
    check("rst_valid", int'(out_valid), 0);
    sys_rst = 1'b0;

    // Equal quarter-rate tones: 1022, 0, -1022, 0 ...
    cfg(32'h4000_0000, 32'h4000_0000, ofs_demo);
    en = 1; out_ready = 1;
    wait_valid();
    for (int i = 0; i < 8; i++) begin
      check("quarter_mix", int'(mix_out), seq_exp(i));
`ifndef MIX_PHASE_OFS_EN
      check("quarter_a_eq_b", int'(tone_a), int'(tone_b));
`endif
      step();
    end

    // Back-pressure: overwrite sets ovf, cfg_clr clears it
    out_ready = 0;
    for (int i = 0; i < 8; i++) step();
    check("hold_ovf", int'(ovf), 1);
    check("hold_valid", int'(out_valid), 1);
    cfg_clr = 1;
    step();
    cfg_clr = 0;
    check("clr_ovf", int'(ovf), 0);
    out_ready = 1;
    for (int i = 0; i < 6; i++) step();

    // Slow ramp: tone_a walks LUT entries 1, 2, 3 ...
    en = 0;
    do_reset();
    cfg(32'h0040_0000, 32'h0, 32'h0);
    en = 1;
    wait_valid();
    for (int i = 1; i <= 8; i++) begin
      check("ramp_a", int'(tone_a), sine_tab[i]);
      check("ramp_b", int'(tone_b), 0);
      check("ramp_mix", int'(mix_out), sine_tab[i]);
      step();
    end
    // Phase-continuous retune mid-stream
    cfg(32'h0080_0000, 32'h0100_0000, 32'h0);
    for (int i = 0; i < 10; i++) step();

    // Reset mid-stream clears outputs on the next edge
    sys_rst = 1'b1;
    step();
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_tone_a", int'(tone_a), 0);
    sys_rst = 1'b0;
    en = 0;
    step();

    // SMP_DIV=4 instance: a pulse every 4 cycles, 3 cycles after each tick
    do_reset();
    cfg(32'h4000_0000, 32'h4000_0000, ofs_demo);
    en_d4 = 1;
    for (int j = 1; j <= 22; j++) begin
      bit exp_v;
      step();
      exp_v = (j >= 7) && ((j - 7) % 4 == 0);
      check("d4_valid", int'(d4_valid), int'(exp_v));
      if (exp_v) check("d4_mix", int'(d4_mix), seq_exp((j - 7) / 4));
    end
    en_d4 = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_clr = ($urandom_range(0, 39) == 0);
      cfg_wr = ($urandom_range(0, 19) == 0);
      sys_rst = ($urandom_range(0, 149) == 0);
      if (cfg_wr) begin
        fcw_a = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 1 << 24));
        fcw_b = $urandom();
        phase_ofs_b = $urandom();
      end
      step();
    end
    en = 0; cfg_wr = 0; cfg_clr = 0; sys_rst = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
